// File: rtl/hwpf_pkg.sv
// Shared types and helpers for the hardware prefetch arbiter.
package hwpf_pkg;

  localparam int unsigned HwpfPaddrW    = 40;
  localparam int unsigned HwpfLineBytes = 64;
  localparam int unsigned HwpfLineOff   = $clog2(HwpfLineBytes);
  localparam int unsigned HwpfLineW     = HwpfPaddrW - HwpfLineOff;

  // Cache-line number for the default address geometry.
  typedef logic [HwpfLineW-1:0] hwpf_line_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BACKOFF
  } hwpf_arb_state_e;

  // Strip the byte offset within a line.
  function automatic hwpf_line_t line_of(input logic [HwpfPaddrW-1:0] addr);
    return addr[HwpfPaddrW-1:HwpfLineOff];
  endfunction

endpackage

// File: rtl/hwpf_line_filter.sv
// Small CAM of recently issued cache lines with FIFO replacement.
// A lookup also matches the line being inserted in the same cycle.
module hwpf_line_filter #(
  parameter int unsigned Depth = 4,
  parameter int unsigned LineW = 34
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [LineW-1:0] lookup_line_i,
  input  logic             insert_valid_i,
  input  logic [LineW-1:0] insert_line_i,
  output logic             hit_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Depth-1:0] valid_q, valid_d;
  logic [LineW-1:0] line_q [Depth];
  logic [LineW-1:0] line_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [Depth-1:0] match;

  // Hit on any valid entry, or on the line being written this cycle.
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      match[i] = valid_q[i] && (line_q[i] == lookup_line_i);
    end
    hit_o = (|match) || (insert_valid_i && (insert_line_i == lookup_line_i));
  end

  // Next-state: clear wins over insert; insert overwrites the oldest entry.
  always_comb begin
    valid_d  = valid_q;
    line_d   = line_q;
    wr_ptr_d = wr_ptr_q;
    if (clear_i) begin
      valid_d  = '0;
      wr_ptr_d = '0;
    end else if (insert_valid_i) begin
      valid_d[wr_ptr_q] = 1'b1;
      line_d[wr_ptr_q]  = insert_line_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
  end

  // Entry storage and write pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      line_q   <= line_d;
    end
  end

endmodule

// File: rtl/hwpf_arbiter.sv
// Round-robin arbiter sharing the hpdcache prefetch port among hardware
// prefetchers. Backs off after CPU traffic and drops recently issued lines.
module hwpf_arbiter
  import hwpf_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned PADDR_W        = 40,
  parameter int unsigned LINE_BYTES     = 64,
  parameter int unsigned FILTER_DEPTH   = 4,
  parameter int unsigned BACKOFF_CYCLES = 4,
  localparam int unsigned SrcW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       lock_i,
  input  logic                       cpu_req_valid_i,
  input  logic [NUM_REQ-1:0]         hwpf_req_valid_i,
  output logic [NUM_REQ-1:0]         hwpf_req_ready_o,
  input  logic [NUM_REQ*PADDR_W-1:0] hwpf_req_addr_i,
  output logic                       dcache_req_valid_o,
  input  logic                       dcache_req_ready_i,
  output logic [PADDR_W-1:0]         dcache_req_addr_o,
  output logic [SrcW-1:0]            dcache_req_src_o,
  output logic                       filter_drop_o
);

  localparam int unsigned LineOff = $clog2(LINE_BYTES);
  localparam int unsigned LineW   = PADDR_W - LineOff;
  localparam int unsigned CntW    = (BACKOFF_CYCLES > 0) ? $clog2(BACKOFF_CYCLES + 1) : 1;

  hwpf_arb_state_e    state_q, state_d;
  logic [PADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic [SrcW-1:0]    slot_src_q, slot_src_d;
  logic [SrcW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]    bo_cnt_q, bo_cnt_d;
  logic               drop_q, drop_d;

  logic [LineW-1:0]   req_line [NUM_REQ];
  logic [LineW-1:0]   gnt_line;
  logic               gnt_found;
  logic [SrcW-1:0]    gnt_idx;
  logic [SrcW-1:0]    cand_idx;
  int unsigned        cand;
  logic               slot_valid;
  logic               grant_ok;
  logic               handshake;
  logic               issue_accept;
  logic               filter_hit;

  assign slot_valid = (state_q == ISSUE);

  // Line number of each requester's address.
  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_line[k] = hwpf_req_addr_i[k*PADDR_W + LineOff +: LineW];
    end
  end

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = SrcW'(cand);
      if (!gnt_found && hwpf_req_valid_i[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  assign gnt_line = req_line[gnt_idx];

  // A new grant needs room in the slot (empty or draining) and no blocker.
  assign grant_ok = (!slot_valid || dcache_req_ready_i) && !lock_i && !flush_i &&
                    (bo_cnt_q == '0) && !cpu_req_valid_i;
  assign handshake    = grant_ok && gnt_found;
  assign issue_accept = slot_valid && dcache_req_ready_i && !flush_i;

  // One-hot ready to the granted requester.
  always_comb begin
    hwpf_req_ready_o = '0;
    if (handshake) hwpf_req_ready_o[gnt_idx] = 1'b1;
  end

  hwpf_line_filter #(
    .Depth (FILTER_DEPTH),
    .LineW (LineW)
  ) u_filter (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (flush_i),
    .lookup_line_i  (gnt_line),
    .insert_valid_i (issue_accept),
    .insert_line_i  (slot_addr_q[PADDR_W-1:LineOff]),
    .hit_o          (filter_hit)
  );

  // Next-state for FSM, slot, pointer, backoff counter and drop pulse.
  always_comb begin
    state_d     = state_q;
    slot_addr_d = slot_addr_q;
    slot_src_d  = slot_src_q;
    rr_ptr_d    = rr_ptr_q;
    drop_d      = 1'b0;
    bo_cnt_d    = bo_cnt_q;

    if (flush_i) begin
      bo_cnt_d = '0;
    end else if (cpu_req_valid_i) begin
      bo_cnt_d = CntW'(BACKOFF_CYCLES);
    end else if (bo_cnt_q != '0) begin
      bo_cnt_d = bo_cnt_q - CntW'(1);
    end

    if (handshake) begin
      rr_ptr_d = (gnt_idx == SrcW'(NUM_REQ - 1)) ? '0 : gnt_idx + SrcW'(1);
    end

    if (flush_i) begin
      state_d     = IDLE;
      slot_addr_d = '0;
      slot_src_d  = '0;
    end else if (handshake && !filter_hit) begin
      state_d                        = ISSUE;
      slot_addr_d                    = '0;
      slot_addr_d[PADDR_W-1:LineOff] = gnt_line;
      slot_src_d                     = gnt_idx;
    end else begin
      // A handshake reaching here was a filter hit: consume and report it.
      drop_d = handshake;
      unique case (state_q)
        IDLE:    if (bo_cnt_d != '0) state_d = BACKOFF;
        ISSUE:   if (dcache_req_ready_i) state_d = IDLE;
        BACKOFF: if (bo_cnt_d == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      slot_addr_q <= '0;
      slot_src_q  <= '0;
      rr_ptr_q    <= '0;
      bo_cnt_q    <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_addr_q <= slot_addr_d;
      slot_src_q  <= slot_src_d;
      rr_ptr_q    <= rr_ptr_d;
      bo_cnt_q    <= bo_cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign dcache_req_valid_o = slot_valid;
  assign dcache_req_addr_o  = slot_addr_q;
  assign dcache_req_src_o   = slot_src_q;
  assign filter_drop_o      = drop_q;

endmodule

// File: tb/tb_hwpf_arbiter.sv
// Self-checking bench for hwpf_arbiter: directed scenarios with literal
// expectations plus a randomized run against a queue-based reference model.
module tb_hwpf_arbiter;

  localparam int unsigned NUM_REQ        = 2;
  localparam int unsigned PADDR_W        = 40;
  localparam int unsigned LINE_BYTES     = 64;
  localparam int unsigned FILTER_DEPTH   = 4;
  localparam int unsigned BACKOFF_CYCLES = 4;
  localparam int unsigned SrcW           = 1;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       flush, lock, cpu;
  logic [NUM_REQ-1:0]         req_valid, req_ready;
  logic [NUM_REQ*PADDR_W-1:0] req_addr;
  logic                       dvalid, dready, drop;
  logic [PADDR_W-1:0]         daddr;
  logic [SrcW-1:0]            dsrc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hwpf_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .PADDR_W        (PADDR_W),
    .LINE_BYTES     (LINE_BYTES),
    .FILTER_DEPTH   (FILTER_DEPTH),
    .BACKOFF_CYCLES (BACKOFF_CYCLES)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .flush_i            (flush),
    .lock_i             (lock),
    .cpu_req_valid_i    (cpu),
    .hwpf_req_valid_i   (req_valid),
    .hwpf_req_ready_o   (req_ready),
    .hwpf_req_addr_i    (req_addr),
    .dcache_req_valid_o (dvalid),
    .dcache_req_ready_i (dready),
    .dcache_req_addr_o  (daddr),
    .dcache_req_src_o   (dsrc),
    .filter_drop_o      (drop)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; lock = 1'b0; cpu = 1'b0; dready = 1'b0;
    req_valid = '0; req_addr = '0;
  endtask

  task automatic set_req(input int k, input logic [PADDR_W-1:0] a);
    req_addr[k*PADDR_W +: PADDR_W] = a;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  bit                 m_slot_v;
  logic [PADDR_W-1:0] m_slot_addr;
  int                 m_slot_src;
  int                 m_ptr;
  int                 m_bo;
  bit                 m_drop;
  logic [PADDR_W-1:0] m_filter[$];

  initial begin
    bit                 found, grant_ok, hs, hit, accept;
    int                 w;
    logic [NUM_REQ-1:0] exp_ready;
    logic [PADDR_W-1:0] line;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_slot_v = 0; m_slot_addr = '0; m_slot_src = 0; m_ptr = 0; m_bo = 0; m_drop = 0;
        m_filter.delete();
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_valid", 64'(dvalid), 64'd0);
        check("rst_addr", 64'(daddr), 64'd0);
        check("rst_drop", 64'(drop), 64'd0);
      end else begin
        found = 0; w = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
          int idx;
          idx = (m_ptr + i) % NUM_REQ;
          if (!found && req_valid[idx]) begin found = 1; w = idx; end
        end
        grant_ok = (!m_slot_v || dready) && !lock && !flush && (m_bo == 0) && !cpu;
        hs = grant_ok && found;
        exp_ready = '0;
        if (hs) exp_ready[w] = 1'b1;

        check("ready", 64'(req_ready), 64'(exp_ready));
        check("dvalid", 64'(dvalid), 64'(m_slot_v));
        if (m_slot_v) begin
          check("daddr", 64'(daddr), 64'(m_slot_addr));
          check("dsrc", 64'(dsrc), 64'(m_slot_src));
        end
        check("drop", 64'(drop), 64'(m_drop));

        accept = m_slot_v && dready;
        line = req_addr[w*PADDR_W +: PADDR_W] / LINE_BYTES;
        if (flush) begin
          m_slot_v = 0; m_filter.delete(); m_bo = 0; m_drop = 0;
        end else begin
          hit = 0;
          foreach (m_filter[j]) if (m_filter[j] == line) hit = 1;
          if (accept && (m_slot_addr / LINE_BYTES) == line) hit = 1;
          if (accept) begin
            m_filter.push_back(m_slot_addr / LINE_BYTES);
            if (m_filter.size() > FILTER_DEPTH) void'(m_filter.pop_front());
            m_slot_v = 0;
          end
          m_drop = hs && hit;
          if (hs && !hit) begin
            m_slot_v = 1; m_slot_addr = line * LINE_BYTES; m_slot_src = w;
          end
          if (hs) m_ptr = (w + 1) % NUM_REQ;
          if (cpu) m_bo = BACKOFF_CYCLES;
          else if (m_bo > 0) m_bo = m_bo - 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("lit_rst_valid", 64'(dvalid), 64'd0);
    check("lit_rst_src", 64'(dsrc), 64'd0);

    // Single issue.
    step(); rst_n = 1'b1;
    req_valid = 2'b01; set_req(0, 40'h10_0000_0040); dready = 1'b1;
    @(negedge clk); check("lit_single_ready", 64'(req_ready), 64'h1);
    step(); req_valid = 2'b00;
    @(negedge clk);
    check("lit_single_valid", 64'(dvalid), 64'd1);
    check("lit_single_addr", 64'(daddr), 64'h10_0000_0040);
    check("lit_single_src", 64'(dsrc), 64'd0);

    // Move the pointer back to 0, then round-robin with both requesting.
    step(); req_valid = 2'b10; set_req(1, 40'h7000);
    @(negedge clk); check("lit_rr_pre", 64'(req_ready), 64'h2);
    for (int k = 0; k < 4; k++) begin
      step(); req_valid = 2'b11;
      set_req(0, 40'h2000 + 40'(k * 64)); set_req(1, 40'h3000 + 40'(k * 64));
      @(negedge clk);
      check("lit_rr_ready", 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k > 0) check("lit_rr_src", 64'(dsrc), 64'((k - 1) % 2));
    end
    step(); req_valid = 2'b00;
    @(negedge clk); check("lit_rr_src_last", 64'(dsrc), 64'd1);

    // Duplicate filtering with same-cycle insert bypass, then eviction.
    step(); req_valid = 2'b01; set_req(0, 40'h4000);
    @(negedge clk); check("lit_dup_first", 64'(req_ready), 64'h1);
    step(); set_req(0, 40'h4010);
    @(negedge clk);
    check("lit_dup_ready", 64'(req_ready), 64'h1);
    check("lit_dup_slot", 64'(daddr), 64'h4000);
    step(); req_valid = 2'b00;
    @(negedge clk);
    check("lit_dup_drop", 64'(drop), 64'd1);
    check("lit_dup_novalid", 64'(dvalid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step(); req_valid = 2'b01; set_req(0, 40'h8000 + 40'(k * 64));
      @(negedge clk);
    end
    step(); req_valid = 2'b00;
    step(); req_valid = 2'b01; set_req(0, 40'h4000);
    @(negedge clk); check("lit_evict_ready", 64'(req_ready), 64'h1);
    step(); req_valid = 2'b00;
    @(negedge clk);
    check("lit_evict_valid", 64'(dvalid), 64'd1);
    check("lit_evict_addr", 64'(daddr), 64'h4000);
    check("lit_evict_nodrop", 64'(drop), 64'd0);

    // CPU backoff: blocked for the CPU cycle plus BACKOFF_CYCLES.
    step(); cpu = 1'b1; req_valid = 2'b01; set_req(0, 40'h9000);
    @(negedge clk); check("lit_bo_cpu", 64'(req_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step(); cpu = 1'b0;
      @(negedge clk); check("lit_bo_wait", 64'(req_ready), 64'd0);
    end
    step();
    @(negedge clk); check("lit_bo_grant", 64'(req_ready), 64'h1);

    // Stall three cycles with lock rising mid-issue.
    step(); req_valid = 2'b00; dready = 1'b0;
    @(negedge clk); check("lit_stall_c0", 64'(daddr), 64'h9000);
    step(); lock = 1'b1;
    @(negedge clk); check("lit_stall_c1", 64'(dvalid), 64'd1);
    step();
    @(negedge clk); check("lit_stall_c2", 64'(daddr), 64'h9000);
    step(); dready = 1'b1; req_valid = 2'b01; set_req(0, 40'hA000);
    @(negedge clk);
    check("lit_lock_accept", 64'(dvalid), 64'd1);
    check("lit_lock_noready", 64'(req_ready), 64'd0);
    step();
    @(negedge clk);
    check("lit_lock_empty", 64'(dvalid), 64'd0);
    check("lit_lock_still", 64'(req_ready), 64'd0);
    step(); lock = 1'b0;
    @(negedge clk); check("lit_unlock", 64'(req_ready), 64'h1);

    // Flush mid-issue clears slot and filter.
    step(); set_req(0, 40'h5000);
    @(negedge clk);
    step(); set_req(0, 40'h5080);
    @(negedge clk); check("lit_fl_slot", 64'(daddr), 64'h5000);
    step(); dready = 1'b0; set_req(0, 40'h5000); flush = 1'b1;
    @(negedge clk);
    check("lit_fl_busy", 64'(daddr), 64'h5080);
    check("lit_fl_noready", 64'(req_ready), 64'd0);
    step(); flush = 1'b0; dready = 1'b1;
    @(negedge clk);
    check("lit_fl_cleared", 64'(dvalid), 64'd0);
    check("lit_fl_regrant", 64'(req_ready), 64'h1);
    step(); req_valid = 2'b00;
    @(negedge clk);
    check("lit_fl_reissue", 64'(dvalid), 64'd1);
    check("lit_fl_addr", 64'(daddr), 64'h5000);

    // Randomized run with occasional asynchronous reset.
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0; idle_inputs();
        step(); step();
        rst_n = 1'b1;
      end
      req_valid = NUM_REQ'($urandom_range(0, 3));
      for (int k = 0; k < NUM_REQ; k++) begin
        set_req(k, 40'h60_0000_0000 + 40'($urandom_range(0, 7) * 64) + 40'($urandom_range(0, 63)));
      end
      cpu    = ($urandom_range(0, 15) == 0);
      flush  = ($urandom_range(0, 31) == 0);
      lock   = ($urandom_range(0, 9) == 0);
      dready = ($urandom_range(0, 3) != 0);
    end

    step(); idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
